spram_responder: RTL and testbench
==================================

# spram_responder

Single-port memory responder that terminates the sprambus request side driven by the memory traffic generators. It accepts write and read requests under a `ready` handshake and stores write data in an internal array. Read data returns on `q`/`q_valid` after a fixed pipeline latency. It gives the traffic generators a deterministic, optionally stalling and optionally faulty target for simulation and for on-chip self-test without DRAM.

## Interface
Parameters:
- `WIDTH`, 32: data width in bits; equals sprambus `WIDTH`.
- `DEPTH`, 16: number of words; must be a power of 2, ≥2.
- `RD_LATENCY`, 3: cycles from read accept to `q_valid`; legal range 1..8.
- `STALL_PERIOD`, 0: 0 means `ready` never stalls; N≥2 means `ready` is low for exactly 1 cycle in every N.
- `FAULT_PERIOD`, 5: every Nth returned read is corrupted; used only with `SPRAM_RESPONDER_FAULT_EN`.

Ports:
- `clk`, in, 1: clock, all logic on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `address`, in, $clog2(DEPTH): word address (sprambus `address`).
- `d`, in, WIDTH: write data (sprambus `d.value`).
- `wrreq`, in, 1: write request.
- `rdreq`, in, 1: read request.
- `ready`, out, 1: responder can accept a request this cycle.
- `q`, out, WIDTH: read data (sprambus `q.value`).
- `q_valid`, out, 1: `q` is valid this cycle (sprambus `q.info.valid`).
- `wr_count`, out, 16: accepted writes, saturating.
- `rd_count`, out, 16: accepted reads, saturating.
- `collision`, out, 1: sticky flag; a cycle had `wrreq & rdreq & ready`.

## Operation
- Accept rule: a write is accepted on `wrreq & ready`. A read is accepted on `rdreq & ready & !wrreq`.
- Simultaneous `wrreq & rdreq & ready`: the write wins, the read is dropped (not returned, not counted), and `collision` is set. `collision` clears only on reset.
- Write: `mem[address] <= d` at the accept edge.
- Read: `mem[address]` is sampled at the accept edge and enters a RD_LATENCY-deep valid/data shift pipeline. Reads are never reordered or merged.
- Read-after-write to the same address in a later cycle returns the new data.
- Requests while `ready`=0 are ignored and have no side effects. The requester must hold or re-issue them.
- Stall generator: a free-running counter 0..STALL_PERIOD-1 drives `ready`=0 when count == STALL_PERIOD-1; otherwise `ready`=1.
- Counters `wr_count` and `rd_count` each increment by 1 per accept and hold at 16'hFFFF.
- Array contents are not reset; they are unspecified at power-up and retained across `reset`.

## Timing
- Reset values: `ready`=0, `q`=0, `q_valid`=0, `wr_count`=0, `rd_count`=0, `collision`=0. The stall counter and the read pipeline are cleared.
- `ready` first rises on the 1st rising edge after `reset` deasserts.
- Read latency: accept at edge k produces `q_valid`=1 with data for edge k+RD_LATENCY, for exactly 1 cycle. `q` holds its last value while `q_valid`=0.
- Throughput: 1 request per cycle while `ready`=1. Back-to-back reads give back-to-back `q_valid`.
- Reset asserted mid-operation: in-flight reads are discarded with no `q_valid`. Reads accepted before reset never return.
- Address wrap-around is natural modulo DEPTH; no out-of-range case exists.

## Configuration
- `SPRAM_RESPONDER_FAULT_EN` defined:
  - A returned-read counter (0..FAULT_PERIOD-1, reset 0) advances on each `q_valid`.
  - When it is at FAULT_PERIOD-1, bit 0 of `q` is inverted for that beat.
  - `rd_count` is unaffected.
- `SPRAM_RESPONDER_FAULT_EN` undefined:
  - No fault logic is built; `q` always equals stored data.

## Test plan
- Reset release, STALL_PERIOD=0 → `ready`=0 during reset, 1 at the first edge after release; all counters 0.
- Write 0x11111111 to addr 3; read addr 3 at the next cycle with RD_LATENCY=3 → `q_valid` 3 edges after the read accept, `q`=0x11111111; `wr_count`=1, `rd_count`=1.
- 16 writes (addr i, data {8{i[3:0]}}), then 16 back-to-back reads → 16 consecutive `q_valid` beats with matching data; a 17th read to address 0 returns 0x00000000.
- STALL_PERIOD=4 with continuous `rdreq` for 12 cycles → `ready` low on cycles 4, 8, 12; exactly 9 reads accepted; `rd_count`=9.
- `wrreq`=`rdreq`=1 at addr 5 with d=0xA5A5A5A5 → write performed, no `q_valid` for that cycle, `collision`=1; a later read of addr 5 returns 0xA5A5A5A5.
- With `SPRAM_RESPONDER_FAULT_EN`, FAULT_PERIOD=5, 10 reads of known data → beats 5 and 10 have bit 0 inverted. Assert `reset` with 2 reads in flight → no further `q_valid`; `collision` and counters return to 0.

Source files
------------

// File: rtl/spram_responder.sv
// Single-port memory responder: ready/accept handshake, fixed-latency read pipeline, optional stall.
// Defining SPRAM_RESPONDER_FAULT_EN builds the periodic read-data fault injector.
module spram_responder #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int RD_LATENCY   = 3,
    parameter int STALL_PERIOD = 0,
    parameter int FAULT_PERIOD = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] address,
    input  logic [WIDTH-1:0]         d,
    input  logic                     wrreq,
    input  logic                     rdreq,
    output logic                     ready,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [15:0]              wr_count,
    output logic [15:0]              rd_count,
    output logic                     collision
);
    localparam bit            STALL_EN   = STALL_PERIOD >= 2;
    localparam int            SW         = STALL_EN ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0] STALL_LAST = STALL_EN ? SW'(STALL_PERIOD - 1) : '0;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  active_q;
    logic [SW-1:0]         stall_cnt_q, stall_cnt_d;
    logic                  wr_acc, rd_acc;
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [WIDTH-1:0]      pipe_data_q [RD_LATENCY];
    logic [WIDTH-1:0]      ret_data;
    logic [WIDTH-1:0]      q_q, q_d;
    logic                  q_valid_q;
    logic [15:0]           wr_count_q, rd_count_q;
    logic                  collision_q;

    // A write always wins over a simultaneous read; the read is simply dropped.
    assign ready  = active_q && !(STALL_EN && (stall_cnt_q == STALL_LAST));
    assign wr_acc = wrreq && ready;
    assign rd_acc = rdreq && ready && !wrreq;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (STALL_EN && active_q) begin
            stall_cnt_d = (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            active_q    <= 1'b1;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[address] <= d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= rd_acc;
            if (rd_acc) begin
                pipe_data_q[0] <= mem[address];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

`ifdef SPRAM_RESPONDER_FAULT_EN
    localparam int            FW         = (FAULT_PERIOD > 1) ? $clog2(FAULT_PERIOD) : 1;
    localparam logic [FW-1:0] FAULT_LAST = FW'(FAULT_PERIOD - 1);

    logic [FW-1:0] fault_cnt_q, fault_cnt_d;

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        ret_data    = pipe_data_q[RD_LATENCY-1];
        if (pipe_vld_q[RD_LATENCY-1]) begin
            fault_cnt_d = (fault_cnt_q == FAULT_LAST) ? '0 : fault_cnt_q + 1'b1;
            if (fault_cnt_q == FAULT_LAST) begin
                ret_data[0] = ~ret_data[0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end
`else
    assign ret_data = pipe_data_q[RD_LATENCY-1];
`endif

    always_comb begin
        q_d = q_q;
        if (pipe_vld_q[RD_LATENCY-1]) begin
            q_d = ret_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            collision_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= pipe_vld_q[RD_LATENCY-1];
            if (wr_acc && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (rd_acc && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (wrreq && rdreq && ready) begin
                collision_q <= 1'b1;
            end
        end
    end

    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;
    assign collision = collision_q;
endmodule

// File: tb/tb_spram_responder.sv
// Scoreboard bench for spram_responder: reads push expected beats, a negedge monitor pops and checks them.
module tb_spram_responder;
    localparam int W   = 32;
    localparam int DEP = 16;
    localparam int LAT = 3;
    localparam int FP  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, wrreq, rdreq;
    logic [3:0]  address;
    logic [31:0] d;
    logic        ready, q_valid, collision;
    logic [31:0] q;
    logic [15:0] wr_count, rd_count;

    logic        reset2, rdreq2;
    logic        ready2, q_valid2, collision2;
    logic [31:0] q2;
    logic [15:0] wr_count2, rd_count2;

    spram_responder #(.WIDTH(W), .DEPTH(DEP), .RD_LATENCY(LAT), .STALL_PERIOD(0), .FAULT_PERIOD(FP)) u_dut (
        .clk(clk), .reset(reset), .address(address), .d(d), .wrreq(wrreq), .rdreq(rdreq),
        .ready(ready), .q(q), .q_valid(q_valid), .wr_count(wr_count), .rd_count(rd_count),
        .collision(collision)
    );

    spram_responder #(.WIDTH(W), .DEPTH(DEP), .RD_LATENCY(LAT), .STALL_PERIOD(4), .FAULT_PERIOD(FP)) u_dut_stall (
        .clk(clk), .reset(reset2), .address(4'd0), .d(32'd0), .wrreq(1'b0), .rdreq(rdreq2),
        .ready(ready2), .q(q2), .q_valid(q_valid2), .wr_count(wr_count2), .rd_count(rd_count2),
        .collision(collision2)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [DEP];
    logic [31:0] q_hold = '0;
    int          cyc = 0;
    int          beat_idx = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b0) begin
            if (q_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_q_valid: q_valid=1 q=%h at cycle %0d, required no beat", q, cyc);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (q !== e.data) begin
                        n_bad++;
                        $display("FAIL read_data: q=%h required %h (cycle %0d)", q, e.data, cyc);
                    end
                    n_cmp++;
                    if (cyc !== e.due) begin
                        n_bad++;
                        $display("FAIL read_latency: beat at cycle %0d required cycle %0d", cyc, e.due);
                    end
                    q_hold = e.data;
                end
            end else begin
                n_cmp++;
                if (q !== q_hold) begin
                    n_bad++;
                    $display("FAIL q_hold: q=%h required %h while q_valid=0 (cycle %0d)", q, q_hold, cyc);
                end
            end
        end
    end

    // Called #1 after a rising edge; the accept happens on the next edge.
    task automatic issue_write(input logic [3:0] a, input logic [31:0] v);
        address = a;
        d       = v;
        wrreq   = 1'b1;
        rdreq   = 1'b0;
        mem_m[a] = v;
        @(posedge clk); #1;
        wrreq = 1'b0;
    endtask

    task automatic issue_read(input logic [3:0] a);
        exp_t e;
        address = a;
        wrreq   = 1'b0;
        rdreq   = 1'b1;
        e.data  = mem_m[a];
`ifdef SPRAM_RESPONDER_FAULT_EN
        if ((beat_idx % FP) == (FP - 1)) e.data[0] = ~e.data[0];
`endif
        beat_idx++;
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
        @(posedge clk); #1;
        rdreq = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (sb.size() == 0);
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1;
        wrreq = 1'b0; rdreq = 1'b0; rdreq2 = 1'b0;
        address = '0; d = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b0)     begin n_bad++; $display("FAIL reset_ready: got %b required 0", ready); end
        n_cmp++; if (q_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_q_valid: got %b required 0", q_valid); end
        n_cmp++; if (q !== 32'h0)        begin n_bad++; $display("FAIL reset_q: got %h required 0", q); end
        n_cmp++; if (wr_count !== 16'h0) begin n_bad++; $display("FAIL reset_wr_count: got %0d required 0", wr_count); end
        n_cmp++; if (rd_count !== 16'h0) begin n_bad++; $display("FAIL reset_rd_count: got %0d required 0", rd_count); end
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL reset_collision: got %b required 0", collision); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge: got %b required 0", ready); end
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL ready_first_edge: got %b required 1", ready); end
    endtask

    task automatic test_single();
        bit ok;
        issue_write(4'd3, 32'h11111111);
        issue_read(4'd3);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_drain: beat not returned, required 1 beat"); end
        n_cmp++; if (wr_count !== 16'd1) begin n_bad++; $display("FAIL single_wr_count: got %0d required 1", wr_count); end
        n_cmp++; if (rd_count !== 16'd1) begin n_bad++; $display("FAIL single_rd_count: got %0d required 1", rd_count); end
    endtask

    task automatic test_back_to_back();
        bit         ok;
        logic [3:0] a;
        for (int i = 0; i < 16; i++) begin
            a = i[3:0];
            issue_write(a, {8{a}});
        end
        for (int i = 0; i < 16; i++) begin
            a = i[3:0];
            issue_read(a);
        end
        issue_read(4'd0);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_drain: beats outstanding, required 0"); end
        n_cmp++; if (wr_count !== 16'd17) begin n_bad++; $display("FAIL b2b_wr_count: got %0d required 17", wr_count); end
        n_cmp++; if (rd_count !== 16'd18) begin n_bad++; $display("FAIL b2b_rd_count: got %0d required 18", rd_count); end
    endtask

    task automatic test_collision();
        bit ok;
        address = 4'd5;
        d       = 32'hA5A5A5A5;
        wrreq   = 1'b1;
        rdreq   = 1'b1;
        mem_m[5] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        n_cmp++; if (collision !== 1'b1)  begin n_bad++; $display("FAIL collision_flag: got %b required 1", collision); end
        n_cmp++; if (wr_count !== 16'd18) begin n_bad++; $display("FAIL collision_wr_count: got %0d required 18", wr_count); end
        n_cmp++; if (rd_count !== 16'd18) begin n_bad++; $display("FAIL collision_rd_count: got %0d required 18", rd_count); end
        repeat (LAT + 2) @(posedge clk);
        #1;
        issue_read(4'd5);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL collision_readback: beat not returned, required 1 beat"); end
        n_cmp++; if (rd_count !== 16'd19) begin n_bad++; $display("FAIL collision_rd_count2: got %0d required 19", rd_count); end
        n_cmp++; if (collision !== 1'b1)  begin n_bad++; $display("FAIL collision_sticky: got %b required 1", collision); end
    endtask

    task automatic test_stall();
        logic exp_rdy;
        @(posedge clk); #1;
        reset2 = 1'b0;
        rdreq2 = 1'b1;
        n_cmp++; if (ready2 !== 1'b0) begin n_bad++; $display("FAIL stall_ready_c0: got %b required 0", ready2); end
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            exp_rdy = ((i % 4) != 0);
            n_cmp++;
            if (ready2 !== exp_rdy) begin
                n_bad++;
                $display("FAIL stall_ready_c%0d: got %b required %b", i, ready2, exp_rdy);
            end
        end
        @(posedge clk); #1;
        rdreq2 = 1'b0;
        n_cmp++; if (rd_count2 !== 16'd9) begin n_bad++; $display("FAIL stall_rd_count: got %0d required 9", rd_count2); end
    endtask

    task automatic test_reset_inflight();
        issue_read(4'd1);
        issue_read(4'd2);
        reset = 1'b1;
        sb.delete();
        beat_idx = 0;
        q_hold = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (q_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_q_valid: got %b required 0", q_valid); end
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL rst_collision: got %b required 0", collision); end
        n_cmp++; if (wr_count !== 16'h0) begin n_bad++; $display("FAIL rst_wr_count: got %0d required 0", wr_count); end
        n_cmp++; if (rd_count !== 16'h0) begin n_bad++; $display("FAIL rst_rd_count: got %0d required 0", rd_count); end
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b required 1", ready); end
    endtask

    task automatic test_fault();
        bit         ok;
        logic [3:0] a;
        for (int i = 0; i < 10; i++) begin
            a = i[3:0];
            issue_read(a);
        end
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fault_drain: beats outstanding, required 0"); end
        n_cmp++; if (rd_count !== 16'd10) begin n_bad++; $display("FAIL fault_rd_count: got %0d required 10", rd_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_collision();
        test_stall();
        test_reset_inflight();
        test_fault();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
